// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith ops and
// bit-serial multiply (shift-add) and unsigned divide (restoring), WIDTH iterations each.
module alu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic             carry,
   output logic             sign,
   output logic             overflow
);

   localparam int unsigned MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLT   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       iop_q, iop_d;   // 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
   logic [WIDTH-1:0] opd_q, opd_d;   // multiplicand or divisor
   logic [WIDTH-1:0] acc_q, acc_d;   // product high half or partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / product low half, or dividend / quotient
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             sign_q, sign_d;
   logic             ovf_q, ovf_d;

   // Single-cycle datapath, driven straight from the request inputs.
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry;
   logic             sc_ovf;
   logic             is_iter;

   always_comb begin
      is_sub   = (alu_control == OP_SUB);
      b_eff    = is_sub ? ~src_b : src_b;
      sum      = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      is_iter  = alu_control[3] && !alu_control[2];
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      case (alu_control)
         OP_ADD: begin
            sc_res   = sum[WIDTH-1:0];
            sc_carry = sum[WIDTH];
            sc_ovf   = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
         end
         OP_SUB: begin
            sc_res   = sum[WIDTH-1:0];
            sc_carry = sum[WIDTH];
            sc_ovf   = (src_a[MSB] != src_b[MSB]) && (sum[MSB] != src_a[MSB]);
         end
         OP_AND:  sc_res = src_a & src_b;
         OP_OR:   sc_res = src_a | src_b;
         OP_XOR:  sc_res = src_a ^ src_b;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         default: sc_res = '0;
      endcase
   end

   // One iteration of the shift-add multiplier and the restoring divider.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] div_acc;
   logic [WIDTH-1:0] div_lo;
   logic [WIDTH-1:0] it_res;

   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
      mul_acc   = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_shift = {acc_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opd_q});
      // When div_ge holds the true difference is below 2^WIDTH, so low bits suffice.
      div_diff  = div_shift[WIDTH-1:0] - opd_q;
      div_acc   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      div_lo    = {lo_q[WIDTH-2:0], div_ge};
      case (iop_q)
         2'b00:   it_res = mul_lo;
         2'b01:   it_res = mul_acc;
         2'b10:   it_res = div_lo;
         default: it_res = div_acc;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      iop_d   = iop_q;
      opd_d   = opd_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (is_iter) begin
                  state_d = StBusy;
                  cnt_d   = '0;
                  iop_d   = alu_control[1:0];
                  acc_d   = '0;
                  opd_d   = alu_control[1] ? src_b : src_a;
                  lo_d    = alu_control[1] ? src_a : src_b;
               end else begin
                  state_d = StDone;
                  res_d   = sc_res;
                  zero_d  = (sc_res == '0);
                  sign_d  = sc_res[MSB];
                  carry_d = sc_carry;
                  ovf_d   = sc_ovf;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = iop_q[1] ? div_acc : mul_acc;
            lo_d  = iop_q[1] ? div_lo : mul_lo;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = StDone;
               cnt_d   = '0;
               res_d   = it_res;
               zero_d  = (it_res == '0);
               sign_d  = it_res[MSB];
               carry_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         iop_q   <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iop_q   <= iop_d;
         opd_q   <= opd_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign alu_result = res_q;
   assign zero       = zero_q;
   assign carry      = carry_q;
   assign sign       = sign_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  input  1  rising-edge clock; only clock in the block.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_control  input  4  opcode.
REQ-008 src_a  input  WIDTH  operand A.
REQ-009 src_b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 alu_result  output  WIDTH  result.
REQ-013 zero, carry, sign, overflow  output  1 each  flags for alu_result.

Function
REQ-014 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned), 1010 DIVU, 1011 REMU; other codes yield result 0.
REQ-015 FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-016 Accept occurs on in_valid && in_ready; operands and opcode are captured that cycle; inputs are ignored outside IDLE.
REQ-017 Single-cycle opcodes (0000-0110 and undefined): IDLE -> DONE; out_valid asserts the cycle after accept.
REQ-018 Iterative opcodes (1000-1011): IDLE -> BUSY; the counter runs exactly WIDTH iterations, one bit per cycle (shift-add multiply, restoring divide), then BUSY -> DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-019 DONE: out_valid=1; alu_result and flags are held stable until out_valid && out_ready, then -> IDLE.
REQ-020 No back-to-back accept in the DONE cycle; the next accept is possible the cycle after the handshake (one bubble).
REQ-021 ADD/SUB compute a WIDTH+1-bit sum: ADD = {0,a}+{0,b}; SUB = {0,a}+{0,~b}+1.
REQ-022 carry = bit WIDTH of that sum for ADD/SUB (SUB: 1 means no borrow, i.e. a >= b unsigned); 0 for all other opcodes.
REQ-023 overflow for ADD = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]); for SUB = (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]); 0 for all other opcodes.
REQ-024 zero = (alu_result == 0); sign = alu_result[WIDTH-1]; both apply to every opcode.
REQ-025 SLT/SLTU: alu_result = {WIDTH-1 zeros, lt}.
REQ-026 DIVU with src_b==0: result all ones; REMU with src_b==0: result = src_a; no exception; latency is unchanged (WIDTH+1).
REQ-027 MUL/MULHU use the full 2*WIDTH-bit unsigned product; no flag other than zero/sign is set.
REQ-028 Flags are registered together with alu_result and change only on the transition into DONE.

Reset
REQ-029 While rst_n=0: state=IDLE, counter=0, in_ready=1, out_valid=0, alu_result=0, all flags 0.
REQ-030 Reset asserted mid-BUSY or in DONE aborts the operation; no result is emitted after release.
REQ-031 After rst_n deasserts, the first accept is possible on the first rising clk edge.

Verification
REQ-032 ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, result 0x80000000, overflow=1, sign=1, carry=0, zero=0.
REQ-033 SUB 0x00000005 - 0x00000005 -> result 0, zero=1, carry=1, overflow=0; SUB 0 - 1 -> 0xFFFFFFFF, carry=0, sign=1.
REQ-034 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result 0xFFFFFFFE after exactly 33 cycles; MUL same operands -> 0x00000001.
REQ-035 DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored; handshake -> IDLE next cycle.
REQ-037 Reset pulse at cycle 10 of a DIVU -> outputs cleared immediately, out_valid never asserts for that op, next ADD completes normally.
